// File: rtl/register_read_responder_pkg.sv
// Shared definitions for the register-space read responder: FSM state encoding,
// counter width and a saturating increment helper.
package register_read_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DRIVE   = 3'd3,
        ST_RELEASE = 3'd4
    } rd_state_e;

    localparam int CNT_W = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/register_read_responder_hold.sv
// N-bit loadable flip-flop block with synchronous active-high clear; holds the
// data word presented to the bus.
module register_read_responder_hold #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_r;

    // Holding register: clear on reset, capture on load, otherwise keep.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_r <= {WIDTH{1'b0}};
        end else if (load) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/register_read_responder.sv
// CPU read-cycle responder for the register space: fetch, wait states, drive+ack,
// release. Optional strobe-hold timeout is enabled by defining READ_TIMEOUT_EN.
module register_read_responder
    import register_read_responder_pkg::*;
#(
    parameter int dataWidth  = 4,
    parameter int addrWidth  = 4,
    parameter int waitCycles = 2
`ifdef READ_TIMEOUT_EN
    ,
    parameter int timeoutCyc = 64
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 busStrobe,
    input  logic                 busRead,
    input  logic                 busSelect,
    input  logic [addrWidth-1:0] busAddr,
    output logic                 rdEn,
    output logic [addrWidth-1:0] rdAddr,
    input  logic [dataWidth-1:0] rdData,
    output logic [dataWidth-1:0] dataOut,
    output logic                 dataOe,
    output logic                 ack,
    output logic                 busy,
    output logic                 abortPulse
);

    // WAIT occupies at least one cycle even when no wait states are configured.
    localparam logic [CNT_W-1:0] WAIT_LAST =
        (waitCycles > 0) ? CNT_W'(waitCycles - 1) : {CNT_W{1'b0}};

    rd_state_e            state_r;
    rd_state_e            state_s;
    logic                 start_s;
    logic                 load_s;
    logic [CNT_W-1:0]     wait_cnt_r;
    logic [addrWidth-1:0] rd_addr_r;
    logic                 rd_en_r;
    logic                 oe_r;
    logic                 ack_r;
    logic                 busy_r;

`ifdef READ_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(timeoutCyc - 1);

    logic [CNT_W-1:0] to_cnt_r;
    logic             need_low_r;
    logic             abort_r;
    logic             timeout_s;

    assign start_s = busStrobe & busRead & busSelect & ~need_low_r;
`else
    assign start_s = busStrobe & busRead & busSelect;
`endif

    // Next-state decode and dataOut load strobe.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
`ifdef READ_TIMEOUT_EN
        timeout_s = 1'b0;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s = ST_FETCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (!busStrobe) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_WAIT;
                    load_s  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!busStrobe) begin
                    state_s = ST_RELEASE;
                end else if (wait_cnt_r >= WAIT_LAST) begin
                    state_s = ST_DRIVE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DRIVE: begin
                if (!busStrobe) begin
                    state_s = ST_RELEASE;
`ifdef READ_TIMEOUT_EN
                end else if (to_cnt_r >= TO_LAST) begin
                    state_s   = ST_RELEASE;
                    timeout_s = 1'b1;
`endif
                end else begin
                    state_s = ST_DRIVE;
                end
            end
            ST_RELEASE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, address capture, wait counter and bus-facing output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            rd_addr_r  <= {addrWidth{1'b0}};
            rd_en_r    <= 1'b0;
            oe_r       <= 1'b0;
            ack_r      <= 1'b0;
            busy_r     <= 1'b0;
            wait_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            rd_en_r <= (state_s == ST_FETCH);
            oe_r    <= (state_s == ST_DRIVE);
            ack_r   <= (state_s == ST_DRIVE);
            busy_r  <= (state_s != ST_IDLE);
            if ((state_r == ST_IDLE) && (state_s == ST_FETCH)) begin
                rd_addr_r <= busAddr;
            end else begin
                rd_addr_r <= rd_addr_r;
            end
            if (state_r == ST_WAIT) begin
                wait_cnt_r <= sat_inc(wait_cnt_r);
            end else begin
                wait_cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

`ifdef READ_TIMEOUT_EN
    // Drive-phase timeout counter, abort pulse and strobe-must-go-low lockout.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_r   <= {CNT_W{1'b0}};
            need_low_r <= 1'b0;
            abort_r    <= 1'b0;
        end else begin
            abort_r <= timeout_s;
            if (state_r == ST_DRIVE) begin
                to_cnt_r <= sat_inc(to_cnt_r);
            end else begin
                to_cnt_r <= {CNT_W{1'b0}};
            end
            if (timeout_s) begin
                need_low_r <= 1'b1;
            end else if (!busStrobe) begin
                need_low_r <= 1'b0;
            end else begin
                need_low_r <= need_low_r;
            end
        end
    end

    assign abortPulse = abort_r;
`else
    assign abortPulse = 1'b0;
`endif

    register_read_responder_hold #(
        .WIDTH(dataWidth)
    ) u_hold (
        .clk  (clk),
        .reset(reset),
        .load (load_s),
        .d    (rdData),
        .q    (dataOut)
    );

    assign rdEn   = rd_en_r;
    assign rdAddr = rd_addr_r;
    assign dataOe = oe_r;
    assign ack    = ack_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_register_read_responder.sv
// Randomized self-checking bench for register_read_responder; expectations come from
// a transaction-level timeline model (cycles since strobe start) and a register array.
module tb_register_read_responder;

    localparam int DW  = 4;
    localparam int AW  = 4;
    localparam int W   = 2;
    localparam int LAT = 2 + W;

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_strobe;
    logic          bus_read;
    logic          bus_select;
    logic [AW-1:0] bus_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] data_out;
    logic          data_oe;
    logic          ack;
    logic          busy;
    logic          abort_pulse;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] last_data;
    int            n_vec = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    // Register file: data is only meaningful while the read request is up.
    assign rd_data = rd_en ? mem[rd_addr] : ~mem[rd_addr];

    register_read_responder dut (
        .clk       (clk),
        .reset     (reset),
        .busStrobe (bus_strobe),
        .busRead   (bus_read),
        .busSelect (bus_select),
        .busAddr   (bus_addr),
        .rdEn      (rd_en),
        .rdAddr    (rd_addr),
        .rdData    (rd_data),
        .dataOut   (data_out),
        .dataOe    (data_oe),
        .ack       (ack),
        .busy      (busy),
        .abortPulse(abort_pulse)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus cycle: strobe held for 'hold' edges, then dropped. chain_out re-raises
    // the strobe for next_addr during RELEASE; chain_in expects that pre-raised strobe.
    task automatic read_txn(input logic [AW-1:0] addr, input int hold, input bit sel,
                            input bit rd, input bit chain_in, input bit chain_out,
                            input logic [AW-1:0] next_addr);
        bit go;
        go = sel & rd;
        if (chain_in) begin
            step();
            check_eq("relax_busy", {31'd0, busy}, 32'd0);
            check_eq("relax_rden", {31'd0, rd_en}, 32'd0);
        end else begin
            bus_addr   = addr;
            bus_select = sel;
            bus_read   = rd;
            bus_strobe = 1'b1;
        end
        for (int k = 1; k <= hold; k++) begin
            step();
            bus_addr = AW'($urandom);
            check_eq("rden", {31'd0, rd_en}, {31'd0, go && (k == 1)});
            if (go) check_eq("rdaddr", {28'd0, rd_addr}, {28'd0, addr});
            check_eq("busy", {31'd0, busy}, {31'd0, go});
            check_eq("ack", {31'd0, ack}, {31'd0, go && (k >= LAT)});
            check_eq("oe", {31'd0, data_oe}, {31'd0, go && (k >= LAT)});
            check_eq("abort", {31'd0, abort_pulse}, 32'd0);
            if (go && k >= 2) check_eq("data", {28'd0, data_out}, {28'd0, mem[addr]});
        end
        if (go && hold >= 2) last_data = mem[addr];
        bus_strobe = 1'b0;
        step();
        check_eq("rel_busy", {31'd0, busy}, {31'd0, go});
        check_eq("rel_ack", {31'd0, ack}, 32'd0);
        check_eq("rel_oe", {31'd0, data_oe}, 32'd0);
        check_eq("rel_data", {28'd0, data_out}, {28'd0, last_data});
        if (chain_out) begin
            bus_addr   = next_addr;
            bus_select = 1'b1;
            bus_read   = 1'b1;
            bus_strobe = 1'b1;
        end else begin
            step();
            check_eq("idle_busy", {31'd0, busy}, 32'd0);
            check_eq("idle_ack", {31'd0, ack}, 32'd0);
            check_eq("idle_data", {28'd0, data_out}, {28'd0, last_data});
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        reset      = 1'b1;
        bus_strobe = 1'b0;
        bus_read   = 1'b0;
        bus_select = 1'b0;
        bus_addr   = 4'h0;
        last_data  = 4'h0;
        step();
        step();
        check_eq("rst_rden", {31'd0, rd_en}, 32'd0);
        check_eq("rst_rdaddr", {28'd0, rd_addr}, 32'd0);
        check_eq("rst_data", {28'd0, data_out}, 32'd0);
        check_eq("rst_oe", {31'd0, data_oe}, 32'd0);
        check_eq("rst_ack", {31'd0, ack}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_abort", {31'd0, abort_pulse}, 32'd0);
        reset = 1'b0;
        step();

        // Basic read, then a write cycle with select high.
        mem[3] = 4'hA;
        read_txn(4'h3, LAT + 2, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        read_txn(4'h7, LAT + 2, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);

        // Strobe dropped during WAIT, then a normal read.
        read_txn(4'h9, 3, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
        read_txn(4'h9, LAT + 1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);

        // Reset while driving the bus.
        bus_addr   = 4'hC;
        bus_select = 1'b1;
        bus_read   = 1'b1;
        bus_strobe = 1'b1;
        repeat (LAT) step();
        check_eq("pre_rst_ack", {31'd0, ack}, 32'd1);
        reset = 1'b1;
        step();
        check_eq("drv_rst_oe", {31'd0, data_oe}, 32'd0);
        check_eq("drv_rst_ack", {31'd0, ack}, 32'd0);
        check_eq("drv_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("drv_rst_data", {28'd0, data_out}, 32'd0);
        reset      = 1'b0;
        bus_strobe = 1'b0;
        last_data  = 4'h0;
        step();
        step();
        check_eq("post_rst_busy", {31'd0, busy}, 32'd0);

        // Back-to-back reads with a single low strobe cycle between.
        mem[1] = 4'h5;
        mem[2] = 4'h6;
        read_txn(4'h1, LAT + 1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h2);
        read_txn(4'h2, LAT + 1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0);

        // Randomized cycles: mixed reads, writes, deselects and early drops.
        for (int t = 0; t < 40; t++) begin
            if (t % 10 == 0) begin
                for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
            end
            read_txn(AW'($urandom), int'($urandom_range(1, 9)),
                     $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     1'b0, 1'b0, 4'h0);
        end

`ifdef READ_TIMEOUT_EN
        // Strobe held past the drive limit: forced release and lockout until low.
        bus_addr   = 4'h5;
        bus_select = 1'b1;
        bus_read   = 1'b1;
        bus_strobe = 1'b1;
        for (int k = 1; k <= LAT + 63; k++) begin
            step();
            check_eq("to_ack", {31'd0, ack}, {31'd0, k >= LAT});
            check_eq("to_abort", {31'd0, abort_pulse}, 32'd0);
        end
        step();
        check_eq("to_rel_ack", {31'd0, ack}, 32'd0);
        check_eq("to_rel_abort", {31'd0, abort_pulse}, 32'd1);
        check_eq("to_rel_busy", {31'd0, busy}, 32'd1);
        step();
        check_eq("to_idle_abort", {31'd0, abort_pulse}, 32'd0);
        check_eq("to_idle_busy", {31'd0, busy}, 32'd0);
        repeat (3) begin
            step();
            check_eq("to_lock_busy", {31'd0, busy}, 32'd0);
            check_eq("to_lock_rden", {31'd0, rd_en}, 32'd0);
        end
        bus_strobe = 1'b0;
        step();
        check_eq("to_low_busy", {31'd0, busy}, 32'd0);
        bus_strobe = 1'b1;
        step();
        check_eq("to_restart_rden", {31'd0, rd_en}, 32'd1);
        bus_strobe = 1'b0;
        step();
        step();
        check_eq("to_end_busy", {31'd0, busy}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
